// File: rtl/hazard_detection_unit.sv
// Stall/flush control for the 5-stage MIPS pipeline: load-use and branch-in-ID
// dependences, memory-busy freeze, and a saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             I_HDU_clk,
    input  logic             I_HDU_rst_n,
    input  logic [4:0]       I_HDU_ID_RS,
    input  logic [4:0]       I_HDU_ID_RT,
    input  logic             I_HDU_ID_UsesRS,
    input  logic             I_HDU_ID_UsesRT,
    input  logic             I_HDU_ID_Branch,
    input  logic             I_HDU_ID_BranchTaken,
    input  logic [4:0]       I_HDU_EXE_regDst,
    input  logic             I_HDU_EXE_RegWrite,
    input  logic             I_HDU_EXE_MemRead,
    input  logic [4:0]       I_HDU_MEM_regDst,
    input  logic             I_HDU_MEM_MemRead,
    input  logic             I_HDU_MemBusy,
    input  logic             I_HDU_CntClr,
    output logic             O_HDU_PCWrite,
    output logic             O_HDU_IFID_Write,
    output logic             O_HDU_IDEX_Bubble,
    output logic             O_HDU_IFID_Flush,
    output logic             O_HDU_Freeze,
    output logic [CNT_W-1:0] O_HDU_StallCnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] HOLD1 = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rs_exe, rt_exe, rs_mem, rt_mem;
    logic             hit_exe, hit_mem;
    logic [1:0]       need;

    always_comb begin
        rs_exe  = I_HDU_ID_UsesRS && (I_HDU_ID_RS == I_HDU_EXE_regDst) && (I_HDU_EXE_regDst != 5'd0);
        rt_exe  = I_HDU_ID_UsesRT && (I_HDU_ID_RT == I_HDU_EXE_regDst) && (I_HDU_EXE_regDst != 5'd0);
        rs_mem  = I_HDU_ID_UsesRS && (I_HDU_ID_RS == I_HDU_MEM_regDst) && (I_HDU_MEM_regDst != 5'd0);
        rt_mem  = I_HDU_ID_UsesRT && (I_HDU_ID_RT == I_HDU_MEM_regDst) && (I_HDU_MEM_regDst != 5'd0);
        hit_exe = rs_exe || rt_exe;
        hit_mem = rs_mem || rt_mem;

        // Ordered priority: a load feeding an ID branch needs the extra cycle.
        if (I_HDU_ID_Branch && I_HDU_EXE_MemRead && hit_exe)
            need = 2'd2;
        else if (I_HDU_EXE_MemRead && hit_exe)
            need = 2'd1;
        else if (I_HDU_ID_Branch && I_HDU_EXE_RegWrite && hit_exe)
            need = 2'd1;
        else if (I_HDU_ID_Branch && I_HDU_MEM_MemRead && hit_mem)
            need = 2'd1;
        else
            need = 2'd0;
    end

    always_comb begin
        O_HDU_PCWrite     = 1'b0;
        O_HDU_IFID_Write  = 1'b0;
        O_HDU_IDEX_Bubble = 1'b0;
        O_HDU_IFID_Flush  = 1'b0;
        O_HDU_Freeze      = 1'b0;
        state_d           = state_q;

        if (!I_HDU_rst_n) begin
            O_HDU_IDEX_Bubble = 1'b1;
            state_d           = IDLE;
        end else if (I_HDU_MemBusy) begin
            O_HDU_Freeze = 1'b1;
        end else if (state_q == HOLD1) begin
            O_HDU_IDEX_Bubble = 1'b1;
            state_d           = IDLE;
        end else if (need != 2'd0) begin
            O_HDU_IDEX_Bubble = 1'b1;
            state_d           = (need == 2'd2) ? HOLD1 : IDLE;
        end else begin
            O_HDU_PCWrite    = 1'b1;
            O_HDU_IFID_Write = 1'b1;
            O_HDU_IFID_Flush = I_HDU_ID_BranchTaken;
        end
    end

    always_ff @(posedge I_HDU_clk or negedge I_HDU_rst_n) begin
        if (!I_HDU_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (I_HDU_CntClr)
                cnt_q <= '0;
            else if (O_HDU_IDEX_Bubble && !I_HDU_MemBusy && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign O_HDU_StallCnt = cnt_q;

endmodule
